// File: rtl/instr_encoder_loader_if.sv
// Command stream and instruction-memory write bus of the RV32I instruction loader.
// The slave modport is the loader's view; the master modport is the view of
// whoever feeds commands and observes the memory writes.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 6
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [4:0]        cmd_rd;
    logic [4:0]        cmd_rs1;
    logic [4:0]        cmd_rs2;
    logic [2:0]        cmd_funct3;
    logic              cmd_f7b5;
    logic [20:0]       cmd_imm;
    logic              cmd_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_funct3, cmd_f7b5,
               cmd_imm, cmd_last,
        output cmd_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_funct3, cmd_f7b5,
               cmd_imm, cmd_last,
        input  cmd_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Sequential RV32I instruction encoder/loader. Takes one field-level command
// every two cycles, encodes it (lw, sw, R-type, beq, jal, jalr) and writes the
// word to consecutive imem word addresses. Illegal commands are dropped and
// flagged on the sticky err output.
module instr_encoder_loader #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    instr_encoder_loader_if.slave  bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [ADDR_W:0]        count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              legal_q, legal_d;
    logic              last_q, last_d;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic [20:0]       imm;
    logic              imm_i_ok;
    logic              imm_b_ok;
    logic [ADDR_W:0]   count_inc;

    // Encode the presented command fields into an instruction word and judge legality.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        enc_word  = '0;
        enc_legal = 1'b0;
        imm       = bus.cmd_imm;
        // 12-bit signed immediates fit when bits 20..11 are a pure sign extension.
        imm_i_ok  = (&imm[20:11]) | ~(|imm[20:11]);
        // beq reaches -4096..4094: bits 20..12 sign-extend and the offset is even.
        imm_b_ok  = ((&imm[20:12]) | ~(|imm[20:12])) & ~imm[0];
        unique case (bus.cmd_op)
            3'd0: begin
                enc_word  = {imm[11:0], bus.cmd_rs1, 3'b010, bus.cmd_rd, 7'b0000011};
                enc_legal = imm_i_ok;
            end
            3'd1: begin
                enc_word  = {imm[11:5], bus.cmd_rs2, bus.cmd_rs1, 3'b010, imm[4:0], 7'b0100011};
                enc_legal = imm_i_ok;
            end
            3'd2: begin
                enc_word  = {1'b0, bus.cmd_f7b5, 5'b00000, bus.cmd_rs2, bus.cmd_rs1,
                             bus.cmd_funct3, bus.cmd_rd, 7'b0110011};
                enc_legal = 1'b1;
            end
            3'd3: begin
                enc_word  = {imm[12], imm[10:5], bus.cmd_rs2, bus.cmd_rs1, 3'b000,
                             imm[4:1], imm[11], 7'b1100011};
                enc_legal = imm_b_ok;
            end
            3'd4: begin
                enc_word  = {imm[20], imm[10:1], imm[11], imm[19:12], bus.cmd_rd, 7'b1101111};
                enc_legal = ~imm[0];
            end
            3'd5: begin
                enc_word  = {imm[11:0], bus.cmd_rs1, 3'b000, bus.cmd_rd, 7'b1100111};
                enc_legal = imm_i_ok;
            end
            default: begin
                enc_word  = '0;
                enc_legal = 1'b0;
            end
        endcase
    end

    // Next-state and next-output computation for the load session FSM.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        count_d     = count_q;
        legal_d     = legal_q;
        last_d      = last_q;
        count_inc   = count_q + 1'b1;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    addr_d      = BASE_C;
                    count_d     = '0;
                    err_d       = 1'b0;
                    done_d      = 1'b0;
                    busy_d      = 1'b1;
                    cmd_ready_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    state_d     = S_WRITE;
                    cmd_ready_d = 1'b0;
                    we_d        = enc_legal;
                    wdata_d     = enc_word;
                    legal_d     = enc_legal;
                    last_d      = bus.cmd_last;
                end
            end
            S_WRITE: begin
                we_d = 1'b0;
                if (legal_q) begin
                    addr_d  = addr_q + 1'b1;
                    count_d = count_inc;
                end else begin
                    err_d = 1'b1;
                end
                // Ending on a full count guarantees BASE_ADDR+DEPTH is never written.
                if (last_q || (legal_q && count_inc == DEPTH_C)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d     = S_LOAD;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any session, including a pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
            legal_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            count_q     <= count_d;
            legal_q     <= legal_d;
            last_q      <= last_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign count          = count_q;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Sequential RV32I instruction encoder and writer. It is the inverse of the opcode/control decode path.
- Accepts field-level commands on a valid/ready stream and encodes each into a 32-bit instruction word for lw, sw, R-type, beq, jal or jalr.
- Writes the words to consecutive instruction-memory word addresses.
- Used at bring-up and in benches to load programs into imem before the pipeline runs.

Parameters:
- ADDR_W, 6, imem word-address width.
- BASE_ADDR, 0, first word address written after start.
- DEPTH, 64, number of words the loader may write; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load session (ignored unless IDLE or DONE).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_op  in  3  0=lw 1=sw 2=R-type 3=beq 4=jal 5=jalr; 6,7 illegal.
- cmd_rd  in  5  destination register.
- cmd_rs1  in  5  source register 1.
- cmd_rs2  in  5  source register 2.
- cmd_funct3  in  3  used for R-type only.
- cmd_f7b5  in  1  funct7 bit 5, R-type only (1 = sub/sra).
- cmd_imm  in  21  signed immediate, byte offset.
- cmd_last  in  1  final command of the session.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  session active (LOAD or WRITE).
- done  out  1  session finished.
- err  out  1  sticky; at least one command was rejected.
- count  out  ADDR_W+1  words written this session.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE. All outputs 0: cmd_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count. Reset mid-session aborts immediately; a partial write is not completed.
- FSM states:
  - IDLE: start -> LOAD; addr←BASE_ADDR, count←0, err←0, done←0.
  - LOAD: cmd_ready=1. A handshake (cmd_valid & cmd_ready) registers the encoded word and a legality flag, then -> WRITE.
  - WRITE: cmd_ready=0.
    - Legal command: imem_we=1 for exactly this cycle, with addr/wdata stable.
    - Illegal command: imem_we=0 and err←1.
    - After a legal write, addr and count increment.
    - Next state is DONE if cmd_last, or if count reaches DEPTH after the increment; otherwise LOAD.
  - DONE: done=1, busy=0. start -> LOAD with the same initialisation as IDLE.
- Throughput: one command per 2 cycles. Latency from handshake to imem_we is 1 cycle.
- Full: when count==DEPTH the session ends even without cmd_last. No write ever targets BASE_ADDR+DEPTH.
- cmd_last on an illegal command still ends the session.
- start while busy is ignored.
- Field encoding, with funct3 fixed at 010 for lw/sw and 000 for beq/jalr:
  - lw: imm[11:0] | rs1 | 010 | rd | 0000011.
  - sw: imm[11:5] | rs2 | rs1 | 010 | imm[4:0] | 0100011.
  - R-type: 0,f7b5,00000 | rs2 | rs1 | funct3 | rd | 0110011.
  - beq: imm[12] | imm[10:5] | rs2 | rs1 | 000 | imm[4:1] | imm[11] | 1100011.
  - jal: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | 1101111.
  - jalr: imm[11:0] | rs1 | 000 | rd | 1100111.
- Illegal commands (not written; err set):
  - cmd_op of 6 or 7.
  - lw/sw/jalr with imm outside −2048..2047 (i.e. cmd_imm[20:11] not all equal).
  - beq with imm outside −4096..4094 or with imm[0]=1.
  - jal with imm[0]=1.
- Unused fields are ignored (e.g. rd for sw/beq).

Test Plan:
- start; lw rd=5 rs1=2 imm=8, last=0 -> one cycle after handshake: imem_we=1, addr=0, wdata=0x00812283; count=1; back in LOAD.
- Session sw rs2=6 rs1=2 imm=12; add rd=3 rs1=1 rs2=2 f3=0 f7b5=0; sub with f7b5=1, last=1 -> wdata 0x00612623, 0x002081B3, 0x402081B3 at addr 0,1,2; then done=1, busy=0, count=3.
- beq rs1=1 rs2=2 imm=−8 -> 0xFE208CE3; jal rd=1 imm=16 -> 0x010000EF; cmd_ready low during each WRITE cycle.
- beq imm=3, then op=7, then lw imm=4096 -> no imem_we for any of them; err=1 and stays 1 after a following legal write; count excludes rejected commands.
- DEPTH=4 with 6 commands, none last -> exactly 4 writes at addr 0..3; done after the 4th write; no write to addr 4.
- rst_n low in the WRITE cycle -> imem_we and all outputs 0 immediately; after release: IDLE, no further writes until start.
